// File: rtl/seg_scan_display_if.sv
// Bus between the countdown stage and the 6-digit multiplexed 7-segment scanner.
// The upstream side (master) drives values and state; the scanner (slave) drives digit select and segments.
interface seg_scan_display_if;
    logic [6:0] cnt;
    logic [2:0] cnt_state;
    logic [6:0] score_a;
    logic [6:0] score_b;
    logic [5:0] sel;
    logic [7:0] seg;

    modport master (
        output cnt,
        output cnt_state,
        output score_a,
        output score_b,
        input  sel,
        input  seg
    );

    modport slave (
        input  cnt,
        input  cnt_state,
        input  score_a,
        input  score_b,
        output sel,
        output seg
    );
endinterface

// File: rtl/seg_scan_display.sv
// 6-digit common-anode scanner: score A on digits 5:4, countdown on 3:2, score B on 1:0, blinking the countdown in pause.
// Optional macro LEADING_ZERO_BLANK_EN blanks a tens digit that is zero.
module seg_scan_display #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLINK_HALF_CYC = 12_500_000
) (
    input  logic                sclk,
    input  logic                nrst,
    seg_scan_display_if.slave   io_bus
);

    localparam int DIV   = CLK_FREQ / SCAN_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLK_W = (BLINK_HALF_CYC > 1) ? $clog2(BLINK_HALF_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF_CYC - 1);
    localparam logic [2:0]       ST_PAUSE = 3'b010;
    localparam logic [2:0]       IDX_LAST = 3'd5;

    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] units_of(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [5:0]       r_sel;
    logic [7:0]       r_seg;
    logic [6:0]       r_snap_cnt;
    logic [6:0]       r_snap_a;
    logic [6:0]       r_snap_b;
    logic [2:0]       r_snap_state;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_hidden;

    logic             w_tick;
    logic             w_wrap;
    logic             w_pause_entry;
    logic [6:0]       w_pair_val;
    logic             w_digit_ok;
    logic [6:0]       w_sat;
    logic [3:0]       w_tens;
    logic [3:0]       w_units;
    logic             w_blink_blank;
    logic [7:0]       w_seg_nxt;
    logic [5:0]       w_sel_nxt;

    // r_idx is the digit shown on the next tick; the tick showing digit 5 closes the frame.
    assign w_tick        = (r_div == DIV_LAST);
    assign w_wrap        = w_tick && (r_idx == IDX_LAST);
    assign w_pause_entry = w_wrap && (io_bus.cnt_state == ST_PAUSE) && (r_snap_state != ST_PAUSE);

    // Scan divider: free-running 0..DIV-1.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Scan index advances once per tick, 0..5.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_idx <= 3'd0;
        end else if (w_tick) begin
            r_idx <= (r_idx >= IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_idx <= r_idx;
        end
    end

    // Frame snapshot taken at the frame wrap so tens and units always come from one value.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_snap_cnt   <= 7'd0;
            r_snap_a     <= 7'd0;
            r_snap_b     <= 7'd0;
            r_snap_state <= 3'd0;
        end else if (w_wrap) begin
            r_snap_cnt   <= io_bus.cnt;
            r_snap_a     <= io_bus.score_a;
            r_snap_b     <= io_bus.score_b;
            r_snap_state <= io_bus.cnt_state;
        end else begin
            r_snap_cnt   <= r_snap_cnt;
            r_snap_a     <= r_snap_a;
            r_snap_b     <= r_snap_b;
            r_snap_state <= r_snap_state;
        end
    end

    // Blink phase generator; restarts visible when the snapshot enters pause.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_blink_cnt    <= '0;
            r_blink_hidden <= 1'b0;
        end else if (w_pause_entry) begin
            r_blink_cnt    <= '0;
            r_blink_hidden <= 1'b0;
        end else if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt    <= '0;
            r_blink_hidden <= ~r_blink_hidden;
        end else begin
            r_blink_cnt    <= r_blink_cnt + BLK_W'(1);
            r_blink_hidden <= r_blink_hidden;
        end
    end

    // Select the snapshot value belonging to the digit pair being scanned.
    always_comb begin
        w_pair_val = 7'd0;
        w_digit_ok = 1'b1;
        case (r_idx)
            3'd0, 3'd1: w_pair_val = r_snap_b;
            3'd2, 3'd3: w_pair_val = r_snap_cnt;
            3'd4, 3'd5: w_pair_val = r_snap_a;
            default: begin
                w_pair_val = 7'd0;
                w_digit_ok = 1'b0;
            end
        endcase
    end

    // Only an exact 010 snapshot blinks; invalid encodings behave as stop.
    assign w_sat         = sat99(w_pair_val);
    assign w_tens        = tens_of(w_sat);
    assign w_units       = units_of(w_sat);
    assign w_blink_blank = (r_snap_state == ST_PAUSE) && r_blink_hidden &&
                           ((r_idx == 3'd2) || (r_idx == 3'd3));
    assign w_sel_nxt     = w_digit_ok ? ~(6'b00_0001 << r_idx) : 6'h3F;

    // Segment pattern for the digit about to be shown.
    always_comb begin
        w_seg_nxt = 8'hFF;
        if (!w_digit_ok) begin
            w_seg_nxt = 8'hFF;
        end else if (w_blink_blank) begin
            w_seg_nxt = 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
        end else if (r_idx[0] && (w_tens == 4'd0)) begin
            w_seg_nxt = 8'hFF;
`endif
        end else begin
            w_seg_nxt = seg_code(r_idx[0] ? w_tens : w_units);
        end
    end

    // Registered pins, updated only on a scan tick.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_sel <= 6'h3F;
            r_seg <= 8'hFF;
        end else if (w_tick) begin
            r_sel <= w_sel_nxt;
            r_seg <= w_seg_nxt;
        end else begin
            r_sel <= r_sel;
            r_seg <= r_seg;
        end
    end

    assign io_bus.sel = r_sel;
    assign io_bus.seg = r_seg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: table of frames, blink, mid-frame change and mid-scan reset.
`timescale 1ns/1ps
module tb_seg_scan_display;

    logic sclk = 1'b0;
    logic nrst = 1'b0;
    always #5 sclk = ~sclk;

    seg_scan_display_if bus ();

    seg_scan_display #(
        .CLK_FREQ      (1000),
        .SCAN_HZ       (100),
        .BLINK_HALF_CYC(40)
    ) dut (
        .sclk  (sclk),
        .nrst  (nrst),
        .io_bus(bus)
    );

    typedef struct {
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    typedef struct packed {
        logic [6:0]  a;
        logic [6:0]  c;
        logic [6:0]  b;
        logic [2:0]  st;
        logic [47:0] segs;   // digit5 .. digit0
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[5];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] last_sel;
    logic [7:0] last_seg;

    localparam logic [47:0] SEGS_ZERO  = 48'hC0C0C0C0C0C0;
    localparam logic [47:0] SEGS_BLINK = 48'hF9A4B0999282;  // a=12 c=34 b=56
    localparam logic [47:0] SEGS_C20   = 48'hF9A4A4C0C092;  // a=12 c=20 b=5
    localparam logic [47:0] SEGS_C19   = 48'hF9A4F990C092;  // a=12 c=19 b=5

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [47:0] segs, input bit h2, input bit h3);
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e.sel    = 6'h3F;
            e.sel[i] = 1'b0;
            e.seg    = segs[8*i +: 8];
`ifdef LEADING_ZERO_BLANK_EN
            if ((i % 2 == 1) && (e.seg == 8'hC0)) e.seg = 8'hFF;
`endif
            if ((i == 2 && h2) || (i == 3 && h3)) e.seg = 8'hFF;
            sb_q.push_back(e);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got no expected entry at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            check("sel", {2'b00, bus.sel}, {2'b00, e.sel});
            check("seg", bus.seg, e.seg);
            last_sel = e.sel;
            last_seg = e.seg;
        end
    endtask

    task automatic run_tick();
        repeat (9) @(posedge sclk);
        #1;
        check("hold_sel", {2'b00, bus.sel}, {2'b00, last_sel});
        check("hold_seg", bus.seg, last_seg);
        @(posedge sclk);
        #1;
        pop_check();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) run_tick();
    endtask

    task automatic set_in(input logic [6:0] a, input logic [6:0] c, input logic [6:0] b, input logic [2:0] st);
        bus.score_a   = a;
        bus.cnt       = c;
        bus.score_b   = b;
        bus.cnt_state = st;
    endtask

    // Blink phase seen k cycles after the pause-entry tick: 40 visible, 40 hidden, ...
    function automatic bit hid(input int k);
        return (((k - 1) / 40) % 2) == 1;
    endfunction

    // Reset, check darkness, then consume the first frame (snapshot 0); returns aligned at a frame wrap.
    task automatic do_reset();
        nrst = 1'b0;
        sb_q.delete();
        repeat (3) @(posedge sclk);
        #1;
        check("rst_sel", {2'b00, bus.sel}, 8'h3F);
        check("rst_seg", bus.seg, 8'hFF);
        @(negedge sclk);
        nrst = 1'b1;
        last_sel = 6'h3F;
        last_seg = 8'hFF;
        push_frame(SEGS_ZERO, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge sclk);
            #1;
            check("dark_sel", {2'b00, bus.sel}, 8'h3F);
            check("dark_seg", bus.seg, 8'hFF);
        end
        @(posedge sclk);
        #1;
        pop_check();
        run_ticks(5);
    endtask

    initial begin
        vecs[0] = {7'd12,  7'd20,  7'd5,   3'b100, 48'hF9A4A4C0C092};
        vecs[1] = {7'd127, 7'd127, 7'd100, 3'b001, 48'h909090909090};
        vecs[2] = {7'd0,   7'd7,   7'd99,  3'b100, 48'hC0C0C0F89090};
        vecs[3] = {7'd38,  7'd64,  7'd81,  3'b011, 48'hB080829980F9};
        vecs[4] = {7'd10,  7'd99,  7'd56,  3'b000, 48'hF9C090909282};

        set_in(7'd0, 7'd0, 7'd0, 3'b100);
        do_reset();
        push_frame(SEGS_ZERO, 1'b0, 1'b0);

        // Table: each vector is shown one frame after it is driven.
        for (int v = 0; v < 5; v++) begin
            set_in(vecs[v].a, vecs[v].c, vecs[v].b, vecs[v].st);
            push_frame(vecs[v].segs, 1'b0, 1'b0);
            run_ticks(6);
        end

        // Play, then pause: countdown digits blink from the pause-entry wrap.
        set_in(7'd12, 7'd34, 7'd56, 3'b100);
        push_frame(SEGS_BLINK, 1'b0, 1'b0);
        run_ticks(6);
        set_in(7'd12, 7'd34, 7'd56, 3'b010);
        for (int f = 1; f <= 7; f++) begin
            push_frame(SEGS_BLINK, hid(60 * (f - 1) + 30), hid(60 * (f - 1) + 40));
            run_ticks(6);
        end

        // Invalid state: never blanks over several frames.
        set_in(7'd12, 7'd34, 7'd56, 3'b011);
        for (int f = 0; f < 5; f++) begin
            push_frame(SEGS_BLINK, 1'b0, 1'b0);
            run_ticks(6);
        end

        // Mid-frame change of cnt only appears at the next frame.
        set_in(7'd12, 7'd20, 7'd5, 3'b100);
        push_frame(SEGS_C20, 1'b0, 1'b0);
        run_ticks(6);
        run_ticks(3);
        bus.cnt = 7'd19;
        push_frame(SEGS_C19, 1'b0, 1'b0);
        run_ticks(3);
        push_frame(SEGS_C19, 1'b0, 1'b0);
        run_ticks(6);

        // Reset in the middle of a scan: immediate darkness, restart at digit 0 with snapshot 0.
        run_ticks(3);
        repeat (4) @(posedge sclk);
        #1;
        nrst = 1'b0;
        #1;
        check("async_sel", {2'b00, bus.sel}, 8'h3F);
        check("async_seg", bus.seg, 8'hFF);
        do_reset();
        push_frame(SEGS_C19, 1'b0, 1'b0);
        run_ticks(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream consumer of the countdown stage. Drives a multiplexed 6-digit common-anode 7-segment display.
- Digit layout: digits 5:4 show score A, digits 3:2 show the countdown value, digits 1:0 show score B.
- Converts binary values to BCD and scans the digits at a fixed rate.
- Blinks the countdown digits while the countdown is paused.

Parameters:
- CLK_FREQ, 50_000_000: sclk frequency in Hz.
- SCAN_HZ, 1000: digit-advance rate in Hz. Scan divider DIV = CLK_FREQ/SCAN_HZ, i.e. one tick every DIV cycles.
- BLINK_HALF_CYC, 12_500_000: sclk cycles per blink half-period (250 ms at default clock).

Ports:
- sclk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- cnt  in  7  countdown value (binary, 0..127).
- cnt_state  in  3  one-hot countdown state: 100 = play, 010 = pause, 001 = stop.
- score_a  in  7  score A (binary).
- score_b  in  7  score B (binary).
- sel  out  6  digit select, active low, bit i = digit i.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset values: sel=6'b111111, seg=8'hFF, scan index=0, scan divider=0, blink phase=visible, all snapshots=0.
- Scan divider:
  - Counts 0..DIV-1 and wraps. The cycle where it equals DIV-1 is a "tick".
  - On each tick, the scan index advances 0→1→…→5→0.
  - sel and seg are registered and update on the tick: sel has a single 0 at the new index, seg carries that digit's pattern.
  - Latency from tick to pins is 1 clock. Before the first tick after reset, the display is fully dark.
- Frame snapshot:
  - cnt, score_a, score_b and cnt_state are sampled into internal registers on the tick where the index wraps 5→0.
  - The whole frame uses the snapshot, so there is no tearing between the tens and units digits.
- Binary→BCD conversion:
  - Values above 99 saturate to 99.
  - tens = v/10, units = v%10.
  - Digit i even = units of its pair, digit i odd = tens.
- Segment codes (active low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Blank=FF. dp is always 1 (off).
- Blink:
  - A free counter 0..BLINK_HALF_CYC-1 toggles the blink phase on each wrap.
  - Entering pause (snapshot state changes to 010 from anything else) forces phase=visible and clears the blink counter.
  - In pause with phase=hidden, digits 3:2 output FF; digits 5:4 and 1:0 are unaffected.
  - In play and stop, all digits are always visible.
- Invalid cnt_state (not exactly one-hot) is treated as stop: no blinking.
- Input changes between frame boundaries have no effect until the next 5→0 wrap.
- Reset mid-scan: outputs go to their reset values immediately (asynchronous), and scanning restarts at index 0 on the first tick after release.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: a tens digit equal to 0 outputs FF for every pair (e.g. cnt=7 shows blank, 7). A units digit is never blanked.
- Undefined: tens digits always show their numeral (cnt=7 shows 0, 7).

Test Plan:
- Use CLK_FREQ=1000, SCAN_HZ=100 (DIV=10), BLINK_HALF_CYC=40 for all scenarios.
- Reset then release -> sel=3F, seg=FF for 9 cycles after release. On tick 1, sel=3E, seg for units of score B (snapshot 0) = C0.
- score_a=12, cnt=20, score_b=5, state=100, run 2 frames -> second frame sel/seg pairs:
  - 3E/92, 3D/C0, 3B/C0, 37/A4, 2F/A4, 1F/F9.
  - With LEADING_ZERO_BLANK_EN, digit1 = FF.
- cnt=127 -> digits 3:2 show 9,9 (90, 90).
- state switched 100→010 just before a frame wrap -> digits 3:2 visible for 40 cycles, then FF for 40 cycles, repeating. Digits 5:4 and 1:0 unchanged.
- cnt changed 20→19 mid-frame -> the current frame still shows 2,0. The next frame shows 1,9 (F9, 90).
- state=011 (invalid) -> no blanking on digits 3:2 over 200 cycles.
